// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared states, length codes and load helpers for mem_bus_arbiter
package mem_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_IOWAIT,
        S_DONE
    } state_t;

    localparam logic [2:0] LEN_B = 3'd1;
    localparam logic [2:0] LEN_H = 3'd2;
    localparam logic [2:0] LEN_W = 3'd4;

    localparam logic [1:0] IO_HI_DEFAULT = 2'b11;

    // Anything that is not a byte or halfword moves a full word.
    function automatic logic [2:0] norm_len(input logic [2:0] len);
        case (len)
            LEN_B:   return LEN_B;
            LEN_H:   return LEN_H;
            default: return LEN_W;
        endcase
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] w,
                                                input logic [2:0]  len,
                                                input logic        sgn);
        case (len)
            LEN_B:   return sgn ? {{24{w[7]}},  w[7:0]}  : {24'd0, w[7:0]};
            LEN_H:   return sgn ? {{16{w[15]}}, w[15:0]} : {16'd0, w[15:0]};
            default: return w;
        endcase
    endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - byte-serial memory bus sequencer shared by fetch and data ports
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   if_req/if_addr                fetch request (level, abortable), 4-byte read
//   if_done/if_data               one-cycle done pulse with fetched word
//   d_req/d_we/d_addr/d_wdata     data request (level, not abortable)
//   d_len/d_signed                byte count 1/2/4 (else 4), sign-extend loads
//   d_done/d_rdata                one-cycle done pulse with load result
//   mem_din                       read byte, valid the cycle after its address
//   io_buffer_full                UART buffer full, lags one cycle
//   mem_dout/mem_a/mem_wr         registered bus outputs
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter logic [1:0] IO_HI = IO_HI_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_len,
    input  logic        d_signed,
    output logic        d_done,
    output logic [31:0] d_rdata,
    input  logic [7:0]  mem_din,
    input  logic        io_buffer_full,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
);

    state_t      state, state_n;
    logic        owner_d, owner_n;
    logic [31:0] addr, addr_n;
    logic [31:0] wdata, wdata_n;
    logic [2:0]  len, len_n;
    logic        sgn, sgn_n;
    logic [2:0]  cnt, cnt_n;
    logic [31:0] rbuf, rbuf_n;

    logic [7:0]  mem_dout_n;
    logic [31:0] mem_a_n;
    logic        mem_wr_n;
    logic        if_done_n, d_done_n;
    logic [31:0] if_data_n, d_rdata_n;

    logic        grant;
    logic        io_last;
    logic [31:0] rword;
    logic [31:0] wshift;

    // The buffer-full flag lags by a cycle, so an I/O byte written last
    // cycle blocks the next one just as a full buffer would.
    assign io_last = mem_wr && (mem_a[17:16] == IO_HI);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            owner_d  <= 1'b0;
            addr     <= '0;
            wdata    <= '0;
            len      <= LEN_W;
            sgn      <= 1'b0;
            cnt      <= '0;
            rbuf     <= '0;
            mem_dout <= '0;
            mem_a    <= '0;
            mem_wr   <= 1'b0;
            if_done  <= 1'b0;
            d_done   <= 1'b0;
            if_data  <= '0;
            d_rdata  <= '0;
        end else begin
            state    <= state_n;
            owner_d  <= owner_n;
            addr     <= addr_n;
            wdata    <= wdata_n;
            len      <= len_n;
            sgn      <= sgn_n;
            cnt      <= cnt_n;
            rbuf     <= rbuf_n;
            mem_dout <= mem_dout_n;
            mem_a    <= mem_a_n;
            mem_wr   <= mem_wr_n;
            if_done  <= if_done_n;
            d_done   <= d_done_n;
            if_data  <= if_data_n;
            d_rdata  <= d_rdata_n;
        end
    end

    always_comb begin
        state_n    = state;
        owner_n    = owner_d;
        addr_n     = addr;
        wdata_n    = wdata;
        len_n      = len;
        sgn_n      = sgn;
        cnt_n      = cnt;
        rbuf_n     = rbuf;
        mem_dout_n = mem_dout;
        mem_a_n    = mem_a;
        mem_wr_n   = 1'b0;
        if_done_n  = 1'b0;
        d_done_n   = 1'b0;
        if_data_n  = if_data;
        d_rdata_n  = d_rdata;
        grant      = 1'b0;
        // In READ, cnt counts edges since the grant; the byte arriving now
        // belongs to address index cnt-1.
        rword      = rbuf | ({24'd0, mem_din} << {cnt - 3'd1, 3'b000});
        // In WRITE, cnt is the number of bytes already put on the bus.
        wshift     = wdata >> {cnt, 3'b000};

        case (state)
            S_IDLE: grant = 1'b1;
            S_READ: begin
                if (!owner_d && !if_req) begin
                    grant = 1'b1;
                end else begin
                    if (cnt + 3'd1 < len)
                        mem_a_n = addr + {29'd0, cnt + 3'd1};
                    if (cnt != 3'd0) begin
                        rbuf_n = rword;
                        if (cnt == len) begin
                            state_n = S_DONE;
                            if (owner_d) begin
                                d_done_n  = 1'b1;
                                d_rdata_n = extend_load(rword, len, sgn);
                            end else begin
                                if_done_n = 1'b1;
                                if_data_n = rword;
                            end
                        end
                    end
                    cnt_n = cnt + 3'd1;
                end
            end
            S_WRITE, S_IOWAIT: begin
                if (cnt == len) begin
                    state_n  = S_DONE;
                    d_done_n = 1'b1;
                end else if (addr[17:16] == IO_HI && (io_buffer_full || io_last)) begin
                    state_n = S_IOWAIT;
                end else begin
                    state_n    = S_WRITE;
                    mem_wr_n   = 1'b1;
                    mem_a_n    = addr + {29'd0, cnt};
                    mem_dout_n = wshift[7:0];
                    cnt_n      = cnt + 3'd1;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        // Grant edge: data port has fixed priority; the first bus cycle of
        // the new transaction is driven on this same edge.
        if (grant) begin
            state_n = S_IDLE;
            if (d_req) begin
                owner_n = 1'b1;
                addr_n  = d_addr;
                wdata_n = d_wdata;
                len_n   = norm_len(d_len);
                sgn_n   = d_signed;
                rbuf_n  = '0;
                cnt_n   = '0;
                if (!d_we) begin
                    state_n = S_READ;
                    mem_a_n = d_addr;
                end else if (d_addr[17:16] == IO_HI && (io_buffer_full || io_last)) begin
                    state_n = S_IOWAIT;
                end else begin
                    state_n    = S_WRITE;
                    mem_wr_n   = 1'b1;
                    mem_a_n    = d_addr;
                    mem_dout_n = d_wdata[7:0];
                    cnt_n      = 3'd1;
                end
            end else if (if_req) begin
                owner_n = 1'b0;
                addr_n  = if_addr;
                len_n   = LEN_W;
                sgn_n   = 1'b0;
                rbuf_n  = '0;
                cnt_n   = '0;
                state_n = S_READ;
                mem_a_n = if_addr;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_len;
    logic        d_signed;
    logic        d_done;
    logic [31:0] d_rdata;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    mem_bus_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_done        (if_done),
        .if_data        (if_data),
        .d_req          (d_req),
        .d_we           (d_we),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_len          (d_len),
        .d_signed       (d_signed),
        .d_done         (d_done),
        .d_rdata        (d_rdata),
        .mem_din        (mem_din),
        .io_buffer_full (io_buffer_full),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int if_done_cnt = 0;
    int d_done_cnt  = 0;
    int last_io_cyc = -100;
    logic        full_at_edge = 1'b0;
    logic [31:0] pend_addr = '0;

    logic [7:0]  byte_mem [logic [31:0]];
    logic [39:0] wq[$];
    int          wcq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        if (byte_mem.exists(a)) return byte_mem[a];
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h3C;
    endfunction

    function automatic int eff_len(input logic [2:0] l);
        return (l == 3'd1) ? 1 : (l == 3'd2) ? 2 : 4;
    endfunction

    // Little-endian assembly of n bytes, then two's-complement extension.
    function automatic logic [31:0] exp_load(input logic [31:0] a, input int n, input bit sgn);
        longint v = 0;
        for (int k = 0; k < n; k++) v = v + (longint'(rd_byte(a + k)) << (8 * k));
        if (sgn && n < 4 && ((v >> (8 * n - 1)) & 1) == 1) v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        full_at_edge <= io_buffer_full;
    end

    // Memory: byte for the address seen last cycle is presented this cycle.
    always @(negedge clk) begin
        mem_din = rd_byte(pend_addr);
        pend_addr = mem_a;
        if (if_done) if_done_cnt++;
        if (d_done) d_done_cnt++;
        if (mem_wr) begin
            byte_mem[mem_a] = mem_dout;
            wq.push_back({mem_a, mem_dout});
            wcq.push_back(cyc);
            if (mem_a[17:16] == 2'b11) begin
                check("io_gate_full", {31'd0, full_at_edge}, 32'd0);
                check("io_gap", {31'd0, (cyc - last_io_cyc) >= 2}, 32'd1);
                last_io_cyc = cyc;
            end
        end
    end

    task automatic data_txn(input bit we, input logic [31:0] a, input logic [31:0] wd,
                            input logic [2:0] l, input bit sgn, input int fc);
        int n, t0, lat, exp_lat;
        bit got, io;
        logic [31:0] exp;
        @(negedge clk);
        wq.delete();
        wcq.delete();
        n   = eff_len(l);
        io  = (a[17:16] == 2'b11);
        exp = exp_load(a, n, sgn);
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_len = l; d_signed = sgn;
        io_buffer_full = (fc > 0);
        t0 = cyc + 1;
        got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            lat = cyc - t0;
            if (lat == fc - 1) io_buffer_full = 1'b0;
            if (!we && lat < n) check("rd_addr", mem_a, a + lat);
            if (d_done) got = 1'b1;
        end
        io_buffer_full = 1'b0;
        check("d_done_seen", {31'd0, got}, 32'd1);
        if (!we)     exp_lat = n + 1;
        else if (io) exp_lat = fc + 2 * (n - 1) + 1;
        else         exp_lat = n;
        check("d_done_lat", cyc - t0, exp_lat);
        if (!we) begin
            check("d_rdata", d_rdata, exp);
        end else begin
            check("mem_wr_after", {31'd0, mem_wr}, 32'd0);
            check("wr_count", wq.size(), n);
            for (int k = 0; k < n && k < wq.size(); k++) begin
                check("wr_addr", wq[k][39:8], a + k);
                check("wr_byte", {24'd0, wq[k][7:0]}, (wd >> (8 * k)) & 32'hFF);
            end
            if (!io && wcq.size() > 0) check("wr_first_cyc", wcq[0] - t0, 0);
        end
        d_req = 1'b0;
        @(negedge clk);
        check("d_done_pulse", {31'd0, d_done}, 32'd0);
    endtask

    task automatic fetch_txn(input logic [31:0] a);
        int t0, lat;
        bit got;
        logic [31:0] exp;
        @(negedge clk);
        exp = exp_load(a, 4, 1'b0);
        if_req = 1'b1; if_addr = a;
        t0 = cyc + 1;
        got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            lat = cyc - t0;
            if (lat < 4) check("if_addr_seq", mem_a, a + lat);
            if (if_done) got = 1'b1;
        end
        check("if_done_seen", {31'd0, got}, 32'd1);
        check("if_done_lat", cyc - t0, 5);
        check("if_data", if_data, exp);
        if_req = 1'b0;
        @(negedge clk);
        check("if_done_pulse", {31'd0, if_done}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_a"}, mem_a, 32'd0);
        check({tag, "_mem_dout"}, {24'd0, mem_dout}, 32'd0);
        check({tag, "_mem_wr"}, {31'd0, mem_wr}, 32'd0);
        check({tag, "_if_done"}, {31'd0, if_done}, 32'd0);
        check({tag, "_d_done"}, {31'd0, d_done}, 32'd0);
        check({tag, "_if_data"}, if_data, 32'd0);
        check({tag, "_d_rdata"}, d_rdata, 32'd0);
    endtask

    initial begin
        int t0, t1, base, kind;
        bit got;
        logic [31:0] a, expv;
        rst = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
        d_wdata = 0; d_len = 0; d_signed = 0; mem_din = 0; io_buffer_full = 0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        byte_mem[32'h100] = 8'h13; byte_mem[32'h101] = 8'h05;
        byte_mem[32'h102] = 8'h00; byte_mem[32'h103] = 8'h00;
        byte_mem[32'h200] = 8'h80;

        fetch_txn(32'h100);
        check("fetch_0x100", if_data, 32'h00000513);

        // Both requests together: data first, fetch after the bubble.
        @(negedge clk);
        if_req = 1; if_addr = 32'h400;
        d_req = 1; d_we = 0; d_addr = 32'h200; d_len = 3'd1; d_signed = 1;
        t0 = cyc + 1; got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (if_done) check("prio_if_early", 32'd1, 32'd0);
            if (d_done) got = 1;
        end
        check("prio_d_seen", {31'd0, got}, 32'd1);
        check("prio_d_lat", cyc - t0, 2);
        check("prio_d_rdata", d_rdata, 32'hFFFFFF80);
        d_req = 0;
        expv = exp_load(32'h400, 4, 0);
        got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (cyc - t0 == 4) check("prio_fetch_addr", mem_a, 32'h400);
            if (if_done) got = 1;
        end
        check("prio_if_seen", {31'd0, got}, 32'd1);
        check("prio_if_lat", cyc - t0, 9);
        check("prio_if_data", if_data, expv);
        if_req = 0;

        data_txn(1, 32'h1000, 32'h12345678, 3'd4, 0, 0);
        data_txn(1, 32'h30000, 32'h41, 3'd1, 0, 3);
        data_txn(1, 32'h30001, 32'hA5B6, 3'd2, 0, 0);
        data_txn(0, 32'hFFFFFFFE, 0, 3'd4, 0, 0);
        data_txn(0, 32'h1000, 0, 3'd2, 1, 0);
        data_txn(0, 32'h1002, 0, 3'd7, 1, 0);

        // Fetch abort after two captured bytes; pending load granted on that edge.
        @(negedge clk);
        base = if_done_cnt;
        if_req = 1; if_addr = 32'h500;
        t0 = cyc + 1;
        while (cyc < t0 + 3) @(negedge clk);
        if_req = 0;
        d_req = 1; d_we = 0; d_addr = 32'h300; d_len = 3'd4; d_signed = 0;
        expv = exp_load(32'h300, 4, 0);
        t1 = cyc + 1; got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (cyc - t1 == 0) check("abort_d_addr", mem_a, 32'h300);
            if (d_done) got = 1;
        end
        check("abort_d_seen", {31'd0, got}, 32'd1);
        check("abort_d_lat", cyc - t1, 5);
        check("abort_d_rdata", d_rdata, expv);
        d_req = 0;
        repeat (3) @(negedge clk);
        check("abort_no_if_done", if_done_cnt - base, 32'd0);

        // Asynchronous reset during the third byte of a word store.
        @(negedge clk);
        base = d_done_cnt;
        d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hCAFEBABE; d_len = 3'd4;
        t0 = cyc + 1;
        while (cyc < t0 + 2) @(negedge clk);
        check("rst_pre_wr", {31'd0, mem_wr}, 32'd1);
        check("rst_pre_addr", mem_a, 32'h2002);
        #1 rst = 1;
        #1 check_all_zero("async_rst");
        d_req = 0;
        #1 rst = 0;
        repeat (4) @(negedge clk);
        check("rst_no_d_done", d_done_cnt - base, 32'd0);
        data_txn(0, 32'h2000, 0, 3'd4, 0, 0);

        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 6);
            a = $urandom;
            if (kind <= 2) begin
                data_txn(0, a, 0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 0);
            end else if (kind <= 4) begin
                if (a[17:16] == 2'b11) a[16] = 1'b0;
                data_txn(1, a, $urandom, 3'($urandom_range(0, 7)), 0, 0);
            end else if (kind == 5) begin
                fetch_txn(a);
            end else begin
                a[17:16] = 2'b11;
                data_txn(1, a, $urandom, 3'($urandom_range(0, 7)), 0, $urandom_range(0, 3));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
